// File: rtl/ones_comp_sched.sv
// Two-requester scheduler in front of a bit-serial ones'-complement subtractor.
// One full-adder slice computes A + ~B in four cycles, then folds in the end-around carry in four more.
module ones_comp_sched (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       ack0,
  output logic       ack1,
  output logic       busy,
  output logic       done,
  output logic [3:0] y,
  output logic       done_id
);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  // Handshake: reqN is a level held until ackN pulses for one cycle; operands
  // are captured on the edge that raises ackN and may change afterwards.
  state_t     state_q;
  logic [3:0] a_q, b_q, sum_q, y_q;
  logic [1:0] bit_q;
  logic       c_q, eac_q, last_q, id_q;
  logic       ack0_q, ack1_q, busy_q, done_q, done_id_q;

  logic fa_a, fa_b, fa_cin, fa_s, fa_co;
  logic any_req, gnt;

  // The single shared full-adder slice and its operand steering.
  always_comb begin
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    case (state_q)
      PASS1: begin
        fa_a   = a_q[bit_q];
        fa_b   = ~b_q[bit_q];
        fa_cin = c_q;
      end
      PASS2: begin
        fa_a   = sum_q[bit_q];
        fa_b   = 1'b0;
        fa_cin = (bit_q == 2'd0) ? eac_q : c_q;
      end
      default: ;
    endcase
    fa_s  = fa_a ^ fa_b ^ fa_cin;
    fa_co = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));
  end

  // Round-robin: on a tie, the requester not granted last wins.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) gnt = ~last_q;
    else              gnt = req1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= 4'd0;
      b_q       <= 4'd0;
      sum_q     <= 4'd0;
      y_q       <= 4'd0;
      bit_q     <= 2'd0;
      c_q       <= 1'b0;
      eac_q     <= 1'b0;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            last_q  <= gnt;
            id_q    <= gnt;
            a_q     <= gnt ? a1 : a0;
            b_q     <= gnt ? b1 : b0;
            ack0_q  <= ~gnt;
            ack1_q  <= gnt;
            busy_q  <= 1'b1;
            bit_q   <= 2'd0;
            c_q     <= 1'b0;
            sum_q   <= 4'd0;
            state_q <= PASS1;
          end
        end
        PASS1: begin
          sum_q[bit_q] <= fa_s;
          c_q          <= fa_co;
          bit_q        <= bit_q + 2'd1;
          if (bit_q == 2'd3) begin
            eac_q   <= fa_co;
            c_q     <= 1'b0;
            state_q <= PASS2;
          end
        end
        PASS2: begin
          sum_q[bit_q] <= fa_s;
          c_q          <= fa_co;
          bit_q        <= bit_q + 2'd1;
          // Final carry-out is dropped; result published on DONE entry.
          if (bit_q == 2'd3) begin
            y_q       <= {fa_s, sum_q[2:0]};
            done_id_q <= id_q;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign y       = y_q;
  assign done_id = done_id_q;

endmodule

// File: tb/tb_ones_comp_sched.sv
// Bench for ones_comp_sched: cycle-level behavioural model with per-cycle compare,
// directed literal cases and randomized request traffic.
module tb_ones_comp_sched;

  logic       clk = 1'b0;
  logic       reset, req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic       ack0, ack1, busy, done, done_id;
  logic [3:0] y;

  int total = 0;
  int bad   = 0;

  ones_comp_sched dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .busy(busy), .done(done),
    .y(y), .done_id(done_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Ones'-complement A - B from plain integer arithmetic.
  function automatic logic [3:0] oc_sub(input logic [3:0] a, input logic [3:0] b);
    int s;
    s = int'(a) + (15 - int'(b));
    if (s > 15) s = s - 16 + 1;
    return 4'(s);
  endfunction

  // Behavioural model: an op occupies 10 cycles from its accepting edge.
  bit         chk_en = 0;
  bit         m_busy, m_last, m_id;
  int         m_cnt;
  logic [3:0] m_a, m_b;
  logic       e_ack0, e_ack1, e_busy, e_done, e_id;
  logic [3:0] e_y;

  always @(posedge clk) begin
    bit g;
    if (reset) begin
      m_busy = 0; m_last = 1; m_cnt = 0; m_id = 0;
      e_ack0 = 0; e_ack1 = 0; e_done = 0; e_y = 4'd0; e_id = 0;
      chk_en = 1;
    end else begin
      e_ack0 = 0; e_ack1 = 0; e_done = 0;
      if (!m_busy) begin
        if (req0 || req1) begin
          g = (req0 && req1) ? !m_last : req1;
          m_last = g;
          m_id   = g;
          m_a    = g ? a1 : a0;
          m_b    = g ? b1 : b0;
          m_busy = 1;
          m_cnt  = 0;
          e_ack0 = !g;
          e_ack1 = g;
        end
      end else begin
        m_cnt++;
        if (m_cnt == 8) begin
          e_done = 1;
          e_y    = oc_sub(m_a, m_b);
          e_id   = m_id;
        end
        if (m_cnt == 9) m_busy = 0;
      end
    end
    e_busy = m_busy;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ack0", ack0, e_ack0);
      check("ack1", ack1, e_ack1);
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("y", y, e_y);
      check("done_id", done_id, e_id);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input bit which, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (which ? ack1 : ack0) return;
    end
    timeout(which ? "wait_ack1" : "wait_ack0");
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (done) return;
    end
    timeout("wait_done");
  endtask

  task automatic run_op(input bit which, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_y, input string name);
    int n;
    if (which) begin a1 = a; b1 = b; req1 = 1; end
    else       begin a0 = a; b0 = b; req0 = 1; end
    wait_ack(which, n);
    if (which) req1 = 0; else req0 = 0;
    wait_done(n);
    check({name, "_latency"}, n, 8);
    check({name, "_y"}, y, exp_y);
    check({name, "_id"}, done_id, which);
  endtask

  initial begin
    int n;
    reset = 1; req0 = 0; req1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    tick(2);
    check("rst_y", y, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", {ack0, ack1, done, done_id}, 0);
    reset = 0;

    run_op(0, 4'd5, 4'd3, 4'b0010, "eac1");
    run_op(1, 4'd3, 4'd5, 4'b1101, "eac0");
    run_op(0, 4'd7, 4'd7, 4'b1111, "negz_a");
    run_op(0, 4'd0, 4'd0, 4'b1111, "negz_b");
    tick(2);

    // Simultaneous requests straight out of reset: requester 0 first.
    reset = 1;
    a0 = 5; b0 = 3; a1 = 3; b1 = 5; req0 = 1; req1 = 1;
    tick(1);
    reset = 0;
    wait_ack(0, n);
    check("tie_first_ack1", ack1, 0);
    check("tie_first_wait", n, 1);
    req0 = 0;
    wait_ack(1, n);
    check("tie_gap", n, 10);
    req1 = 0;
    tick(1);
    req0 = 1; req1 = 1;
    tick(40);
    req0 = 0; req1 = 0;
    tick(12);

    // Reset during PASS2 aborts; held request is re-accepted at once.
    a0 = 5; b0 = 3; req0 = 1;
    wait_ack(0, n);
    tick(6);
    reset = 1;
    tick(1);
    check("abort_outs", {ack0, ack1, busy, done, done_id}, 0);
    check("abort_y", y, 0);
    reset = 0;
    wait_ack(0, n);
    check("reaccept_wait", n, 1);
    req0 = 0;
    wait_done(n);
    check("reaccept_y", y, 4'b0010);

    // Operands altered after ack; req1 raised while busy.
    a0 = 9; b0 = 4; req0 = 1;
    wait_ack(0, n);
    req0 = 0; a0 = 1; b0 = 14;
    a1 = 6; b1 = 2; req1 = 1;
    wait_done(n);
    check("capture_y", y, 4'b0101);
    check("capture_id", done_id, 0);
    wait_ack(1, n);
    check("pending_wait", n, 2);
    req1 = 0;
    wait_done(n);
    check("pending_y", y, 4'b0100);
    check("pending_id", done_id, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (ack0) req0 = 0;
      if (ack1) req1 = 0;
      if (!req0 && $urandom_range(0, 3) == 0) begin
        req0 = 1; a0 = 4'($urandom_range(0, 15)); b0 = 4'($urandom_range(0, 15));
      end
      if (!req1 && $urandom_range(0, 3) == 0) begin
        req1 = 1; a1 = 4'($urandom_range(0, 15)); b1 = 4'($urandom_range(0, 15));
      end
      reset = ($urandom_range(0, 199) == 0);
    end
    reset = 0; req0 = 0; req1 = 0;
    tick(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
